// File: rtl/plugin_delta_accum_pkg.sv
// Shared types and arithmetic helpers for the ISO-16 drift plugins.
// Saturating helpers work on 64-bit values and clamp to a caller-supplied width.
package iso16_plugin_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] sum;
  } sadd_t;

  function automatic int def_rate_x(input int id);
    return 6 * id;
  endfunction

  function automatic int def_rate_y(input int id);
    return 2 * id;
  endfunction

  // Integer division truncates toward zero, matching the legacy rate table.
  function automatic int def_rate_z(input int id);
    return -((6 * id) / 5);
  endfunction

  function automatic sadd_t sat_add(input logic signed [63:0] a,
                                    input logic signed [63:0] b,
                                    input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sadd_t              r;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    s     = a + b;
    r.sat = 1'b0;
    r.sum = s;
    if (s > hi) begin
      r.sum = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] err_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w);
    logic [63:0] s;
    logic [63:0] max;
    max = (64'd1 << w) - 64'd1;
    s   = a + b;
    return (s > max) ? max : s;
  endfunction

endpackage

// File: rtl/plugin_delta_accum_if.sv
// Command/config and result bundle between COLLECT (master) and the drift plugin (slave).
interface plugin_delta_accum_if #(
  parameter int WARP_WIDTH  = 16,
  parameter int ERROR_WIDTH = 32,
  parameter int STEP_WIDTH  = 8
);
  logic                          start;
  logic                          abort;
  logic                          plugin_ack;
  logic                          cfg_use_default;
  logic [STEP_WIDTH-1:0]         cfg_steps;
  logic signed [WARP_WIDTH-1:0]  cfg_rate_x;
  logic signed [WARP_WIDTH-1:0]  cfg_rate_y;
  logic signed [WARP_WIDTH-1:0]  cfg_rate_z;
  logic                          plugin_valid;
  logic                          plugin_busy;
  logic                          plugin_sat;
  logic signed [WARP_WIDTH-1:0]  plugin_warp_x;
  logic signed [WARP_WIDTH-1:0]  plugin_warp_y;
  logic signed [WARP_WIDTH-1:0]  plugin_warp_z;
  logic [ERROR_WIDTH-1:0]        plugin_error;

  modport master (
    output start, abort, plugin_ack, cfg_use_default, cfg_steps,
           cfg_rate_x, cfg_rate_y, cfg_rate_z,
    input  plugin_valid, plugin_busy, plugin_sat,
           plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error
  );

  modport slave (
    input  start, abort, plugin_ack, cfg_use_default, cfg_steps,
           cfg_rate_x, cfg_rate_y, cfg_rate_z,
    output plugin_valid, plugin_busy, plugin_sat,
           plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error
  );
endinterface

// File: rtl/plugin_delta_accum_sat_acc_axis.sv
// One signed saturating drift accumulator; sat_flag marks a clamp on the current step.
module sat_acc_axis
  import iso16_plugin_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] rate,
  output logic signed [W-1:0] acc,
  output logic                sat_flag
);

  sadd_t res;
  logic  unused_hi;

  always_comb begin
    res = sat_add(64'(acc), 64'(rate), W);
  end

  assign sat_flag  = en & res.sat;
  assign unused_hi = ^res.sum[63:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= res.sum[W-1:0];
    end
  end

endmodule

// File: rtl/plugin_delta_accum.sv
// ISO-16 drift plugin: accumulates per-axis signed drift for N steps and holds
// the result under a valid/ack handshake until COLLECT consumes it.
module plugin_delta_accum
  import iso16_plugin_pkg::*;
#(
  parameter int WARP_WIDTH  = 16,
  parameter int ERROR_WIDTH = 32,
  parameter int STEP_WIDTH  = 8,
  parameter int ERR_BASE    = 4,
  parameter int PLUGIN_ID   = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  plugin_delta_accum_if.slave bus
);

  state_t                        state, state_nxt;
  logic [STEP_WIDTH-1:0]         cnt, cnt_inc, n_q;
  logic signed [WARP_WIDTH-1:0]  rate_x_q, rate_y_q, rate_z_q;
  logic signed [WARP_WIDTH-1:0]  sel_x, sel_y, sel_z;
  logic signed [WARP_WIDTH-1:0]  acc_x, acc_y, acc_z;
  logic [2:0]                    sflag;
  logic [1:0]                    nsat;
  logic                          sat_q;
  logic [ERROR_WIDTH-1:0]        err_q, err_new;
  logic [63:0]                   err_step, err_sum;
  logic                          unused_err;
  logic                          clr, step_en, latch;

  assign sel_x = bus.cfg_use_default ? WARP_WIDTH'(def_rate_x(PLUGIN_ID)) : bus.cfg_rate_x;
  assign sel_y = bus.cfg_use_default ? WARP_WIDTH'(def_rate_y(PLUGIN_ID)) : bus.cfg_rate_y;
  assign sel_z = bus.cfg_use_default ? WARP_WIDTH'(def_rate_z(PLUGIN_ID)) : bus.cfg_rate_z;

  assign cnt_inc = cnt + STEP_WIDTH'(1);
  assign nsat    = {1'b0, sflag[0]} + {1'b0, sflag[1]} + {1'b0, sflag[2]};

  always_comb begin
    err_step = err_add(64'(err_q), 64'(ERR_BASE), ERROR_WIDTH);
    err_sum  = err_add(err_step, 64'(nsat), ERROR_WIDTH);
  end
  assign err_new    = err_sum[ERROR_WIDTH-1:0];
  assign unused_err = ^err_sum[63:ERROR_WIDTH];

  // abort outranks start, ack and stepping in every state
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    step_en   = 1'b0;
    latch     = 1'b0;
    if (bus.abort) begin
      state_nxt = IDLE;
      clr       = 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          latch     = 1'b1;
          clr       = 1'b1;
          state_nxt = (bus.cfg_steps == '0) ? HOLD : RUN;
        end
        RUN: begin
          step_en = 1'b1;
          if (cnt_inc == n_q) state_nxt = HOLD;
        end
        HOLD: if (bus.plugin_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      n_q      <= '0;
      rate_x_q <= '0;
      rate_y_q <= '0;
      rate_z_q <= '0;
      sat_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        n_q      <= bus.cfg_steps;
        rate_x_q <= sel_x;
        rate_y_q <= sel_y;
        rate_z_q <= sel_z;
      end
      if (clr) begin
        cnt   <= '0;
        sat_q <= 1'b0;
        err_q <= '0;
      end else if (step_en) begin
        cnt   <= cnt_inc;
        sat_q <= sat_q | (|sflag);
        err_q <= err_new;
      end
    end
  end

  sat_acc_axis #(.W(WARP_WIDTH)) u_axis_x (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(step_en),
    .rate(rate_x_q), .acc(acc_x), .sat_flag(sflag[0])
  );
  sat_acc_axis #(.W(WARP_WIDTH)) u_axis_y (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(step_en),
    .rate(rate_y_q), .acc(acc_y), .sat_flag(sflag[1])
  );
  sat_acc_axis #(.W(WARP_WIDTH)) u_axis_z (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(step_en),
    .rate(rate_z_q), .acc(acc_z), .sat_flag(sflag[2])
  );

  assign bus.plugin_valid  = (state == HOLD);
  assign bus.plugin_busy   = (state == RUN);
  assign bus.plugin_sat    = sat_q;
  assign bus.plugin_error  = err_q;
  assign bus.plugin_warp_x = acc_x;
  assign bus.plugin_warp_y = acc_y;
  assign bus.plugin_warp_z = acc_z;

endmodule

// File: doc/plugin_delta_accum.md
Name: plugin_delta_accum

Overview:
ISO-16 informative drift plugin, next generation of the fixed-bias DELTA plugin. It accumulates a per-axis signed drift rate over a configurable number of steps, with signed saturation. Results are presented through a valid/ack handshake in place of a free-running latched valid. It sits beside the other ISO-16 plugins and feeds the COLLECT stage.

Parameters:
WARP_WIDTH, 16, width of each signed warp axis and rate input
ERROR_WIDTH, 32, width of plugin_error (unsigned)
STEP_WIDTH, 8, width of the step-count config
ERR_BASE, 4, error contribution per accumulation step
PLUGIN_ID, 3, plugin identifier; the default rate set is X=+6*ID, Y=+2*ID, Z=-(6*ID/5) truncated

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  begin accumulation run (honoured in IDLE only)
abort  in  1  cancel run/result, return to IDLE
plugin_ack  in  1  COLLECT has consumed the result
cfg_use_default  in  1  1 = use the PLUGIN_ID rate set; 0 = use cfg_rate_*
cfg_steps  in  STEP_WIDTH  number of accumulation steps N
cfg_rate_x/y/z  in  WARP_WIDTH each  signed per-step drift rates
plugin_valid  out  1  result stable and valid
plugin_busy  out  1  state is RUN
plugin_sat  out  1  at least one axis saturated during the run
plugin_warp_x/y/z  out  WARP_WIDTH each  signed accumulated drift
plugin_error  out  ERROR_WIDTH  ERR_BASE*N + number of saturation events, saturating at all-ones

Behaviour:
- Reset state (asynchronous, rst_n low): state IDLE; all outputs 0; accumulators, step counter, latched rates and saturation count all 0.
- States: IDLE, RUN, HOLD.
- IDLE, start=1 at edge t0:
  - Latch the three rates, chosen by cfg_use_default, and latch N=cfg_steps.
  - Clear accumulators, plugin_sat and the saturation count.
  - N>0: go to RUN.
  - N==0: go directly to HOLD with plugin_valid=1 at t0, warps 0, error 0.
- RUN, one step per edge:
  - acc_a <= sat(acc_a + rate_a) for each axis; step counter increments.
  - sat() clamps to [-2^(W-1), 2^(W-1)-1] (0x8000..0x7FFF at W=16).
  - Each axis clamp in a step adds 1 to the saturation count (0..3 per step) and sets plugin_sat.
  - The step that completes N moves to HOLD and asserts plugin_valid on that same edge.
  - With start at edge t0, valid is first seen high after edge t0+N.
  - Warp outputs track the accumulators every step. They are meaningful only while valid=1.
  - plugin_busy=1 exactly while in RUN.
- Error: plugin_error = ERR_BASE*(steps done) + saturation count. It updates every step and saturates at 2^ERROR_WIDTH-1.
- HOLD:
  - Outputs frozen and plugin_valid=1 until plugin_ack.
  - On ack: go to IDLE, plugin_valid=0 on the next edge. Warp and error values are retained until the next start.
- start in RUN or HOLD: ignored. start and plugin_ack together in HOLD: ack wins, start is ignored; a new start is needed in IDLE.
- abort has priority over all other inputs in any state.
  - Next edge: IDLE, valid=0, busy=0, and warps, error and sat cleared to 0.
  - abort in IDLE also clears retained outputs.
- plugin_ack outside HOLD: ignored.
- N=2^STEP_WIDTH-1: the step counter must not wrap before completion; the counter is STEP_WIDTH bits and compares against N.
- cfg_* inputs are sampled only at start. Changes during RUN or HOLD have no effect.
- Reset asserted mid-RUN or mid-HOLD: immediate return to the reset state, with no partial result visible.

Decomposition:
- Package iso16_plugin_pkg:
  - state enum {IDLE, RUN, HOLD}
  - default-rate constants as functions of PLUGIN_ID
  - signed saturating-add function returning {sum, sat_flag}
  - saturating unsigned error-add function
- Sub-module sat_acc_axis: one signed saturating accumulator with clear, step enable and sat_flag output, instantiated three times.
- The top level holds the FSM, step counter, error/saturation count and handshake.

Test Plan:
- Basic run: cfg_use_default=0, rates x=18, y=6, z=-3, N=4, start pulse -> valid after 4 steps; x=72 (0x0048), y=24 (0x0018), z=-12 (0xFFF4), error=16, sat=0, busy high for 4 cycles.
- Default rates, PLUGIN_ID=3, N=1 -> x=0x0012, y=0x0006, z=0xFFFD, error=4.
- Saturation: x=0x4000, y=z=0, N=3 -> x=0x7FFF, sat=1; clamps at steps 2 and 3 give error=12+2=14.
- Zero steps: N=0, start -> valid next edge, warps 0, error 0, busy never high. Then ack -> valid=0, state IDLE.
- Handshake:
  - Hold valid for 10 cycles with no ack; outputs are unchanged throughout.
  - Ack and start in the same cycle -> returns to IDLE, no new run.
  - A later start reruns and gives identical results.
- Abort and reset:
  - Abort at step 2 of N=5 -> IDLE next edge, all outputs 0.
  - Separately, rst_n low mid-RUN -> outputs 0 immediately (asynchronous), IDLE on release.
